framebuf_ctrl: RTL and testbench
================================

# framebuf_ctrl

Double-buffer and configuration scheduler in front of `ledpanel`. It owns the BRAM buffer select, and swaps front/back buffers only at a panel frame boundary on request from the writers. It round-robin-arbitrates two pixel writers onto the single back-buffer write port. It shadows panel configuration and applies committed changes tear-free at frame end.

## Interface
- `N_ROWS_MAX`, 64, max panel rows
- `N_COLS_MAX`, 256, max chained columns
- `BITDEPTH_MAX`, 8, max bits per colour
- `LSB_BLANK_MAX`, 200, max LSB blanking cycles
- `CTRL_WIDTH`, 32, config word width
- `AW`, $clog2(N_ROWS_MAX*N_COLS_MAX), write address width (derived)
- `DW`, 3*BITDEPTH_MAX, write pixel width (derived)

Ports:
- `clk`  in  1  single clock; everything is synchronous to it
- `ctrl_rst_n`  in  1  asynchronous, active-low reset
- `cfg_n_rows`, `cfg_n_cols`, `cfg_bitdepth`, `cfg_lsb_blank`  in  CTRL_WIDTH each  requested config
- `cfg_commit`  in  1  pulse: capture cfg_* into shadow
- `pnl_frame_end`  in  1  pulse from panel: last bitplane of last row done
- `pnl_en`  out  1  panel enable
- `pnl_buffer`  out  1  front buffer index
- `pnl_n_rows`, `pnl_n_cols`, `pnl_bitdepth`, `pnl_lsb_blank`  out  CTRL_WIDTH each  active config
- `wr0_req`, `wr1_req`  in  1  write request
- `wr0_addr`, `wr1_addr`  in  AW  pixel address
- `wr0_data`, `wr1_data`  in  DW  pixel data
- `wr0_gnt`, `wr1_gnt`  out  1  write accepted this cycle
- `wr_swap_req`  in  1  pulse: back buffer complete
- `wr_swap_ack`  out  1  pulse: swap done
- `swap_pending`  out  1  swap waiting for frame end
- `mem_wr_en`  out  1  BRAM write strobe
- `mem_wr_buffer`  out  1  always ~pnl_buffer
- `mem_wr_addr`  out  AW  BRAM write address
- `mem_wr_data`  out  DW  BRAM write data
- `frame_cnt`  out  16  frames displayed, wraps

## Operation
- Swap FSM, two states:
  - IDLE: on `wr_swap_req`, go to PENDING.
  - PENDING: on `pnl_frame_end`, toggle `pnl_buffer`, pulse `wr_swap_ack` for one cycle, go to IDLE.
  - `wr_swap_req` while PENDING is ignored.
  - `wr_swap_req` and `pnl_frame_end` in the same IDLE cycle: go to PENDING, no swap that frame.
- `swap_pending` = (state == PENDING).
- While PENDING, both grants are forced low, so the outgoing back buffer is frozen.
- Arbiter:
  - `wrN_gnt` is combinational from `wrN_req`, the state, and `last`.
  - Both requesting: grant the port that is not `last`. `last` updates on every grant.
  - An accepted write (req & gnt) is registered: `mem_wr_en`/`mem_wr_addr`/`mem_wr_data` follow next cycle.
  - Without a grant, `mem_wr_en` is 0.
- Config shadow:
  - `cfg_commit` captures cfg_* clamped: rows to [1,N_ROWS_MAX], cols to [1,N_COLS_MAX], bitdepth to [1,BITDEPTH_MAX], lsb_blank to [0,LSB_BLANK_MAX]. It also sets `dirty`.
  - Shadow is copied to pnl_* on `pnl_frame_end` when `dirty`; `dirty` clears.
  - Commit and frame_end in the same cycle: new values are captured, `dirty` stays set, and they apply at the next frame_end.
  - Repeated commits: last one wins.
- First start:
  - While `pnl_en`=0, a commit applies immediately: pnl_* update the cycle after commit.
  - `pnl_en` rises the cycle after that.
  - `pnl_en` stays 1 until reset.
- `frame_cnt` increments on every `pnl_frame_end` while `pnl_en`=1, wrapping FFFF→0.

## Timing
- Reset values: `pnl_en`=0, `pnl_buffer`=0, `mem_wr_buffer`=1, pnl_*=0, gnts=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `wr_swap_ack`=0, `swap_pending`=0, `frame_cnt`=0.
- Reset internal state: `dirty`=0, `last`=1 (wr0 wins first), state=IDLE.
- Reset assertion mid-operation clears everything immediately, including a pending swap and shadow values; writers must re-request.
- Latencies:
  - req → gnt: 0 cycles.
  - gnt → `mem_wr_en`: 1 cycle.
  - frame_end → `pnl_buffer` toggle, `wr_swap_ack`, and config update: 1 cycle, all in the same cycle.
- `mem_wr_buffer` changes together with `pnl_buffer`. The first grant after swap writes the new back buffer.

## Structure
- Package `framebuf_pkg`: swap-state enum (IDLE, PENDING), `clamp` function, `AW`/`DW` derivation constants, shared with `ledpanel` wiring.
- Sub-module `rr_arbiter2`: 2-way round-robin, inputs req[1:0] and block, output gnt[1:0], owns `last`.

## Test plan
- Reset release, `cfg_commit` with rows=5, cols=5, bitdepth=4, lsb_blank=5 → pnl_* = 5,5,4,5 one cycle later; `pnl_en`=1 the cycle after.
- Commit bitdepth=12 and rows=0 → clamped to 8 and 1. Commit mid-frame with pnl_en=1 → pnl_* unchanged until `pnl_frame_end`, then updated one cycle later.
- Both writers requesting continuously for 6 cycles → gnt alternates wr0,wr1,wr0,…; `mem_wr_addr` mirrors the granted address one cycle later; `mem_wr_buffer`=1.
- `wr_swap_req`, then 10 cycles of requests, then `pnl_frame_end` → no grants while pending; `pnl_buffer` 0→1, `mem_wr_buffer`=0, one-cycle `wr_swap_ack`; grants resume.
- `wr_swap_req` coincident with `pnl_frame_end` → no swap; swap happens at the following frame_end. `frame_cnt` at FFFF plus one frame_end → 0.
- Assert `ctrl_rst_n` low while PENDING with writes in flight → all outputs at reset values immediately; no ack after release.

Source files
------------

// File: rtl/framebuf_ctrl_pkg.sv
// Shared constants, swap-state encoding and config clamp helpers for the
// frame buffer controller and the panel wiring.
package framebuf_pkg;

  localparam int N_ROWS_MAX    = 64;
  localparam int N_COLS_MAX    = 256;
  localparam int BITDEPTH_MAX  = 8;
  localparam int LSB_BLANK_MAX = 200;
  localparam int CTRL_WIDTH    = 32;
  localparam int AW            = $clog2(N_ROWS_MAX * N_COLS_MAX);
  localparam int DW            = 3 * BITDEPTH_MAX;
  localparam int N_CFG         = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

  typedef logic [CTRL_WIDTH-1:0] ctrl_word_t;

  function automatic ctrl_word_t clamp(input ctrl_word_t v, input ctrl_word_t lo,
                                       input ctrl_word_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Config word order: 0 rows, 1 cols, 2 bitdepth, 3 lsb_blank.
  function automatic ctrl_word_t cfg_lo(input int idx);
    return (idx == 3) ? '0 : CTRL_WIDTH'(1);
  endfunction

  function automatic ctrl_word_t cfg_hi(input int idx);
    case (idx)
      0:       return CTRL_WIDTH'(N_ROWS_MAX);
      1:       return CTRL_WIDTH'(N_COLS_MAX);
      2:       return CTRL_WIDTH'(BITDEPTH_MAX);
      default: return CTRL_WIDTH'(LSB_BLANK_MAX);
    endcase
  endfunction

endpackage

// File: rtl/framebuf_ctrl_if.sv
// Bus bundle between the frame buffer controller and its writers, the panel
// and the buffer BRAM. The controller takes the slave side.
interface framebuf_ctrl_if;
  import framebuf_pkg::*;

  ctrl_word_t    cfg_n_rows, cfg_n_cols, cfg_bitdepth, cfg_lsb_blank;
  logic          cfg_commit;
  logic          pnl_frame_end;
  logic          pnl_en;
  logic          pnl_buffer;
  ctrl_word_t    pnl_n_rows, pnl_n_cols, pnl_bitdepth, pnl_lsb_blank;
  logic          wr0_req, wr1_req;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          wr0_gnt, wr1_gnt;
  logic          wr_swap_req;
  logic          wr_swap_ack;
  logic          swap_pending;
  logic          mem_wr_en;
  logic          mem_wr_buffer;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [15:0]   frame_cnt;

  modport master (
    output cfg_n_rows, cfg_n_cols, cfg_bitdepth, cfg_lsb_blank, cfg_commit,
    output pnl_frame_end,
    output wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data, wr_swap_req,
    input  pnl_en, pnl_buffer, pnl_n_rows, pnl_n_cols, pnl_bitdepth, pnl_lsb_blank,
    input  wr0_gnt, wr1_gnt, wr_swap_ack, swap_pending,
    input  mem_wr_en, mem_wr_buffer, mem_wr_addr, mem_wr_data, frame_cnt
  );

  modport slave (
    input  cfg_n_rows, cfg_n_cols, cfg_bitdepth, cfg_lsb_blank, cfg_commit,
    input  pnl_frame_end,
    input  wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data, wr_swap_req,
    output pnl_en, pnl_buffer, pnl_n_rows, pnl_n_cols, pnl_bitdepth, pnl_lsb_blank,
    output wr0_gnt, wr1_gnt, wr_swap_ack, swap_pending,
    output mem_wr_en, mem_wr_buffer, mem_wr_addr, mem_wr_data, frame_cnt
  );
endinterface

// File: rtl/framebuf_ctrl_arb.sv
// Two-way round-robin arbiter with a combinational grant; r_last remembers
// the most recent winner so the other port wins the next tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_block,
  output logic [1:0] o_gnt
);
  logic r_last;

  assign o_gnt[0] = ~i_block & i_req[0] & (~i_req[1] | r_last);
  assign o_gnt[1] = ~i_block & i_req[1] & (~i_req[0] | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (o_gnt[0]) begin
      r_last <= 1'b0;
    end else if (o_gnt[1]) begin
      r_last <= 1'b1;
    end
  end
endmodule

// File: rtl/framebuf_ctrl.sv
// Double-buffer swap scheduler, back-buffer write arbiter and tear-free
// panel configuration shadow.
module framebuf_ctrl
  import framebuf_pkg::*;
(
  input  logic           clk,
  input  logic           ctrl_rst_n,
  framebuf_ctrl_if.slave bus
);
  swap_state_e   r_state, w_state_next;
  logic          w_swap_fire;
  logic          r_buffer;
  logic          r_ack;
  logic [1:0]    w_gnt;
  logic          r_mem_en;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;
  logic          r_dirty;
  logic          r_arm;
  logic          r_en;
  logic [15:0]   r_frame_cnt;
  ctrl_word_t    w_cfg_req [N_CFG];
  ctrl_word_t    w_cfg_clamp [N_CFG];
  ctrl_word_t    r_shadow [N_CFG];
  ctrl_word_t    r_pnl [N_CFG];

  always_comb begin
    w_state_next = r_state;
    w_swap_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.wr_swap_req) w_state_next = PENDING;
      end
      PENDING: begin
        if (bus.pnl_frame_end) begin
          w_state_next = IDLE;
          w_swap_fire  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      r_state  <= IDLE;
      r_buffer <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_buffer <= r_buffer ^ w_swap_fire;
      r_ack    <= w_swap_fire;
    end
  end

  // Grants are frozen while a swap waits, and also while reset is held.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (ctrl_rst_n),
    .i_req   ({bus.wr1_req, bus.wr0_req}),
    .i_block ((r_state == PENDING) | ~ctrl_rst_n),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_mem_en <= |w_gnt;
      if (w_gnt[1]) begin
        r_mem_addr <= bus.wr1_addr;
        r_mem_data <= bus.wr1_data;
      end else if (w_gnt[0]) begin
        r_mem_addr <= bus.wr0_addr;
        r_mem_data <= bus.wr0_data;
      end
    end
  end

  assign w_cfg_req[0] = bus.cfg_n_rows;
  assign w_cfg_req[1] = bus.cfg_n_cols;
  assign w_cfg_req[2] = bus.cfg_bitdepth;
  assign w_cfg_req[3] = bus.cfg_lsb_blank;

  // Before the panel runs, a commit goes straight to the active config.
  generate
    for (genvar gi = 0; gi < N_CFG; gi++) begin : g_cfg
      assign w_cfg_clamp[gi] = clamp(w_cfg_req[gi], cfg_lo(gi), cfg_hi(gi));

      always_ff @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
          r_shadow[gi] <= '0;
          r_pnl[gi]    <= '0;
        end else begin
          if (bus.cfg_commit) r_shadow[gi] <= w_cfg_clamp[gi];
          if (bus.cfg_commit && !r_en) begin
            r_pnl[gi] <= w_cfg_clamp[gi];
          end else if (bus.pnl_frame_end && r_dirty) begin
            r_pnl[gi] <= r_shadow[gi];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      r_dirty     <= 1'b0;
      r_arm       <= 1'b0;
      r_en        <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (bus.cfg_commit) begin
        r_dirty <= r_en;
      end else if (bus.pnl_frame_end) begin
        r_dirty <= 1'b0;
      end
      r_arm <= r_arm | (bus.cfg_commit & ~r_en);
      r_en  <= r_en | r_arm;
      if (bus.pnl_frame_end && r_en) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.pnl_en        = r_en;
  assign bus.pnl_buffer    = r_buffer;
  assign bus.pnl_n_rows    = r_pnl[0];
  assign bus.pnl_n_cols    = r_pnl[1];
  assign bus.pnl_bitdepth  = r_pnl[2];
  assign bus.pnl_lsb_blank = r_pnl[3];
  assign bus.wr0_gnt       = w_gnt[0];
  assign bus.wr1_gnt       = w_gnt[1];
  assign bus.wr_swap_ack   = r_ack;
  assign bus.swap_pending  = (r_state == PENDING);
  assign bus.mem_wr_en     = r_mem_en;
  assign bus.mem_wr_buffer = ~r_buffer;
  assign bus.mem_wr_addr   = r_mem_addr;
  assign bus.mem_wr_data   = r_mem_data;
  assign bus.frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_framebuf_ctrl.sv
// Directed bench for framebuf_ctrl: config start-up and clamping, writer
// arbitration, buffer swap timing, frame counter wrap and mid-swap reset.
module tb_framebuf_ctrl;
  import framebuf_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  framebuf_ctrl_if bus ();

  framebuf_ctrl dut (
    .clk        (clk),
    .ctrl_rst_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int rows, input int cols, input int bd, input int lsb);
    bus.cfg_n_rows    = rows;
    bus.cfg_n_cols    = cols;
    bus.cfg_bitdepth  = bd;
    bus.cfg_lsb_blank = lsb;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    set_cfg(0, 0, 0, 0);
    bus.cfg_commit    = 1'b0;
    bus.pnl_frame_end = 1'b0;
    bus.wr0_req       = 1'b0;
    bus.wr1_req       = 1'b0;
    bus.wr0_addr      = '0;
    bus.wr1_addr      = '0;
    bus.wr0_data      = '0;
    bus.wr1_data      = '0;
    bus.wr_swap_req   = 1'b0;
    repeat (3) tick();

    check_eq("rst_pnl_en", 32'(bus.pnl_en), 0);
    check_eq("rst_pnl_buffer", 32'(bus.pnl_buffer), 0);
    check_eq("rst_mem_wr_buffer", 32'(bus.mem_wr_buffer), 1);
    check_eq("rst_pnl_n_rows", bus.pnl_n_rows, 0);
    check_eq("rst_mem_wr_en", 32'(bus.mem_wr_en), 0);
    check_eq("rst_swap_pending", 32'(bus.swap_pending), 0);
    check_eq("rst_frame_cnt", 32'(bus.frame_cnt), 0);
    $display("reset state checked");

    rst_n = 1'b1;
    tick();
    set_cfg(5, 5, 4, 5);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    check_eq("start_rows", bus.pnl_n_rows, 5);
    check_eq("start_cols", bus.pnl_n_cols, 5);
    check_eq("start_bitdepth", bus.pnl_bitdepth, 4);
    check_eq("start_lsb", bus.pnl_lsb_blank, 5);
    check_eq("start_en_low", 32'(bus.pnl_en), 0);
    tick();
    check_eq("start_en_high", 32'(bus.pnl_en), 1);
    $display("first commit: rows=%0d en=%0b", bus.pnl_n_rows, bus.pnl_en);

    set_cfg(0, 300, 12, 250);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    tick();
    check_eq("held_rows", bus.pnl_n_rows, 5);
    check_eq("held_bitdepth", bus.pnl_bitdepth, 4);
    bus.pnl_frame_end = 1'b1;
    tick();
    bus.pnl_frame_end = 1'b0;
    check_eq("clamp_rows", bus.pnl_n_rows, 1);
    check_eq("clamp_cols", bus.pnl_n_cols, 256);
    check_eq("clamp_bitdepth", bus.pnl_bitdepth, 8);
    check_eq("clamp_lsb", bus.pnl_lsb_blank, 200);
    check_eq("frame_cnt_1", 32'(bus.frame_cnt), 1);
    $display("clamped commit applied at frame end: rows=%0d bd=%0d", bus.pnl_n_rows, bus.pnl_bitdepth);

    bus.wr0_addr = 14'h010;
    bus.wr1_addr = 14'h020;
    bus.wr0_data = 24'h00000a;
    bus.wr1_data = 24'h00000b;
    bus.wr0_req  = 1'b1;
    bus.wr1_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq("rr_gnt0", 32'(bus.wr0_gnt), (i % 2 == 0) ? 1 : 0);
      check_eq("rr_gnt1", 32'(bus.wr1_gnt), (i % 2 == 1) ? 1 : 0);
      tick();
      check_eq("rr_mem_en", 32'(bus.mem_wr_en), 1);
      check_eq("rr_mem_addr", 32'(bus.mem_wr_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
      check_eq("rr_mem_data", 32'(bus.mem_wr_data), (i % 2 == 0) ? 32'ha : 32'hb);
      check_eq("rr_mem_buffer", 32'(bus.mem_wr_buffer), 1);
      $display("write %0d: addr=%0h", i, bus.mem_wr_addr);
    end
    bus.wr0_req = 1'b0;
    bus.wr1_req = 1'b0;
    tick();
    check_eq("idle_mem_en", 32'(bus.mem_wr_en), 0);

    bus.wr_swap_req = 1'b1;
    tick();
    bus.wr_swap_req = 1'b0;
    check_eq("swap_pending", 32'(bus.swap_pending), 1);
    bus.wr0_req = 1'b1;
    bus.wr1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("frozen_gnt", {30'd0, bus.wr1_gnt, bus.wr0_gnt}, 0);
      tick();
      check_eq("frozen_mem_en", 32'(bus.mem_wr_en), 0);
    end
    bus.pnl_frame_end = 1'b1;
    tick();
    bus.pnl_frame_end = 1'b0;
    check_eq("swap_buffer", 32'(bus.pnl_buffer), 1);
    check_eq("swap_mem_buffer", 32'(bus.mem_wr_buffer), 0);
    check_eq("swap_ack", 32'(bus.wr_swap_ack), 1);
    check_eq("swap_done_pending", 32'(bus.swap_pending), 0);
    check_eq("frame_cnt_2", 32'(bus.frame_cnt), 2);
    check_eq("resume_gnt0", 32'(bus.wr0_gnt), 1);
    tick();
    check_eq("ack_one_cycle", 32'(bus.wr_swap_ack), 0);
    check_eq("resume_mem_en", 32'(bus.mem_wr_en), 1);
    check_eq("resume_addr", 32'(bus.mem_wr_addr), 32'h10);
    bus.wr0_req = 1'b0;
    bus.wr1_req = 1'b0;
    $display("swap done: buffer=%0b", bus.pnl_buffer);

    bus.wr_swap_req   = 1'b1;
    bus.pnl_frame_end = 1'b1;
    tick();
    bus.wr_swap_req   = 1'b0;
    bus.pnl_frame_end = 1'b0;
    check_eq("coinc_no_swap", 32'(bus.pnl_buffer), 1);
    check_eq("coinc_pending", 32'(bus.swap_pending), 1);
    check_eq("coinc_no_ack", 32'(bus.wr_swap_ack), 0);
    check_eq("frame_cnt_3", 32'(bus.frame_cnt), 3);
    tick();
    bus.pnl_frame_end = 1'b1;
    tick();
    bus.pnl_frame_end = 1'b0;
    check_eq("late_swap_buffer", 32'(bus.pnl_buffer), 0);
    check_eq("late_swap_ack", 32'(bus.wr_swap_ack), 1);
    check_eq("frame_cnt_4", 32'(bus.frame_cnt), 4);
    $display("coincident swap deferred one frame");

    bus.pnl_frame_end = 1'b1;
    repeat (65531) tick();
    check_eq("frame_cnt_ffff", 32'(bus.frame_cnt), 32'hffff);
    tick();
    bus.pnl_frame_end = 1'b0;
    check_eq("frame_cnt_wrap", 32'(bus.frame_cnt), 0);
    $display("frame counter wrapped");

    bus.wr0_req     = 1'b1;
    bus.wr_swap_req = 1'b1;
    tick();
    bus.wr_swap_req = 1'b0;
    check_eq("pre_rst_pending", 32'(bus.swap_pending), 1);
    check_eq("pre_rst_mem_en", 32'(bus.mem_wr_en), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pending", 32'(bus.swap_pending), 0);
    check_eq("mid_rst_mem_en", 32'(bus.mem_wr_en), 0);
    check_eq("mid_rst_pnl_en", 32'(bus.pnl_en), 0);
    check_eq("mid_rst_rows", bus.pnl_n_rows, 0);
    check_eq("mid_rst_mem_buffer", 32'(bus.mem_wr_buffer), 1);
    check_eq("mid_rst_gnt0", 32'(bus.wr0_gnt), 0);
    bus.wr0_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.pnl_frame_end = 1'b1;
    tick();
    bus.pnl_frame_end = 1'b0;
    check_eq("post_rst_no_ack", 32'(bus.wr_swap_ack), 0);
    check_eq("post_rst_buffer", 32'(bus.pnl_buffer), 0);
    check_eq("post_rst_frame_cnt", 32'(bus.frame_cnt), 0);
    $display("reset during pending swap cleared state");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
